// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO.
// Multiply is shift-add (multiplier LSB-first); divide is restoring
// (quotient MSB-first). BITS_PER_CYCLE bits are retired per CALC iteration.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// CALC  | one multiply/divide iteration per enabled edge, counter runs down
// FIX   | sign correction, HI/LO write, done pulse on the way back to IDLE
module muldiv_sequencer #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_req,
    output logic [31:0] hi_read,
    output logic [31:0] lo_read,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [5:0] N_CNT = 6'(32 / BITS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  op_q;
    logic        neg_q;      // product/quotient needs negation
    logic        rem_neg_q;  // remainder takes a negative dividend's sign
    logic        divz_q;
    logic [5:0]  count;
    logic [31:0] opnd;       // |multiplicand| or |divisor|
    logic [63:0] acc;        // mult: {partial hi, multiplier}; div: {raw dividend, quotient}
    logic [32:0] rem;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        load;
    logic        mt_ok;
    logic        sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] mul_next;
    logic [31:0] div_q_next;
    logic [32:0] div_r_next;
    logic [32:0] sum;
    logic [32:0] r_sh;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;

    assign hi_read = hi_q;
    assign lo_read = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign stall   = busy_q & (start | mthi | mtlo | rd_req);

    // Operand conditioning at command acceptance: magnitudes for signed ops.
    always_comb begin
        sgn   = ~op[0];
        abs_a = (sgn && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
        abs_b = (sgn && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (clk_enable) begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
            done_q <= (state == FIX);
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        mt_ok      = 1'b0;
        case (state)
            IDLE: begin
                mt_ok = ~start;
                if (start) begin
                    load       = 1'b1;
                    next_state = (op[1] && (operand_b == 32'd0)) ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == 6'd1) next_state = FIX;
            end
            FIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One CALC iteration: BITS_PER_CYCLE single-bit steps chained.
    always_comb begin
        mul_next   = acc;
        div_q_next = acc[31:0];
        div_r_next = rem;
        sum        = '0;
        r_sh       = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sum      = mul_next[0] ? ({1'b0, mul_next[63:32]} + {1'b0, opnd})
                                   : {1'b0, mul_next[63:32]};
            mul_next = {sum, mul_next[31:1]};

            r_sh       = {div_r_next[31:0], div_q_next[31]};
            div_q_next = {div_q_next[30:0], 1'b0};
            if (r_sh >= {1'b0, opnd}) begin
                div_r_next    = r_sh - {1'b0, opnd};
                div_q_next[0] = 1'b1;
            end else begin
                div_r_next = r_sh;
            end
        end
    end

    // Final HI/LO values, including the divide-by-zero convention.
    always_comb begin
        hi_fix = '0;
        lo_fix = '0;
        if (!op_q[1]) begin
            {hi_fix, lo_fix} = neg_q ? (64'd0 - acc) : acc;
        end else if (divz_q) begin
            hi_fix = acc[63:32];
            lo_fix = 32'hFFFF_FFFF;
        end else begin
            lo_fix = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
            hi_fix = rem_neg_q ? (32'd0 - rem[31:0]) : rem[31:0];
        end
    end

    // Datapath, counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            count     <= '0;
            opnd      <= '0;
            acc       <= '0;
            rem       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (clk_enable) begin
            if (load) begin
                op_q      <= op;
                count     <= N_CNT;
                rem       <= '0;
                neg_q     <= sgn & (operand_a[31] ^ operand_b[31]);
                rem_neg_q <= sgn & operand_a[31];
                divz_q    <= op[1] & (operand_b == 32'd0);
                if (!op[1]) begin
                    acc  <= {32'd0, abs_b};
                    opnd <= abs_a;
                end else begin
                    acc  <= {operand_a, abs_a};
                    opnd <= abs_b;
                end
            end
            if (state == CALC) begin
                count <= count - 6'd1;
                if (!op_q[1]) begin
                    acc <= mul_next;
                end else begin
                    acc[31:0] <= div_q_next;
                    rem       <= div_r_next;
                end
            end
            if (state == FIX) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
            if (mt_ok && mthi) hi_q <= wdata;
            if (mt_ok && mtlo) lo_q <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        clk_enable4;
    logic        start;
    logic        start4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_req;
    logic [31:0] hi_read, lo_read, hi4, lo4;
    logic        busy, done, stall, busy4, done4, stall4;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    muldiv_sequencer #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .operand_a(a), .operand_b(b), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .rd_req(rd_req), .hi_read(hi_read), .lo_read(lo_read),
        .busy(busy), .done(done), .stall(stall)
    );

    muldiv_sequencer #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable4), .start(start4),
        .op(op), .operand_a(a), .operand_b(b), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .rd_req(rd_req), .hi_read(hi4), .lo_read(lo4),
        .busy(busy4), .done(done4), .stall(stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference {HI, LO} for one command.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int     qi, ri;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {ri, qi};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge (edge 1) and records its expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(o, x, y));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(inout int edges, output bit ok);
        while (!done && edges < 200) begin
            tick();
            edges++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (hi_read !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_read); end
        checks++; if (lo_read !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_read); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy4 !== 1'b0 || hi4 !== 32'd0 || lo4 !== 32'd0) begin errors++; $display("FAIL reset_dut4 busy=%b hi=%h lo=%h exp 0", busy4, hi4, lo4); end
    endtask

    task automatic test_multu_max();
        int edges;
        bit ok;
        logic [63:0] e;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        edges = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy got=%b exp=1", busy); end
        wait_done(edges, ok);
        checks++; if (!ok || edges != 34) begin errors++; $display("FAIL multu_latency got=%0d exp=34", edges); end
        e = exp_q.pop_front();
        checks++; if ({hi_read, lo_read} !== e || e !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_result got=%h_%h exp=%h", hi_read, lo_read, e); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_end got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width got=%b exp=0", done); end
    endtask

    task automatic test_signed_and_random();
        int edges;
        bit ok;
        logic [63:0] e;
        logic [1:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: begin o = 2'd0; x = 32'hFFFF_FFFD; y = 32'd5; end
                1: begin o = 2'd2; x = 32'hFFFF_FFF9; y = 32'd2; end
                2: begin o = 2'd2; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: begin o = 2'd2; x = 32'd7;         y = 32'hFFFF_FFFE; end
                default: begin
                    o = 2'($urandom_range(0, 3));
                    x = $urandom;
                    y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
                    if (i % 4 == 0) x = -x;
                end
            endcase
            issue(o, x, y);
            edges = 1;
            wait_done(edges, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || edges != 34 || {hi_read, lo_read} !== e) begin
                errors++;
                $display("FAIL calc_%0d op=%0d a=%h b=%h got=%h_%h edges=%0d exp=%h edges=34", i, o, x, y, hi_read, lo_read, edges, e);
            end
        end
        checks++; if (model(2'd0, 32'hFFFF_FFFD, 32'd5) !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL model_mult_sanity"); end
    endtask

    task automatic test_div_zero();
        int edges;
        bit ok;
        logic [63:0] e;
        issue(2'd3, 32'd5, 32'd0);
        edges = 1;
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || edges != 2) begin errors++; $display("FAIL divu0_latency got=%0d exp=2", edges); end
        checks++; if (hi_read !== 32'd5 || lo_read !== 32'hFFFF_FFFF || {hi_read, lo_read} !== e) begin errors++; $display("FAIL divu0_result got=%h_%h exp=00000005_ffffffff", hi_read, lo_read); end
        issue(2'd2, 32'hDEAD_BEEF, 32'd0);
        edges = 1;
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || edges != 2 || {hi_read, lo_read} !== e) begin errors++; $display("FAIL div0_result got=%h_%h edges=%0d exp=%h edges=2", hi_read, lo_read, edges, e); end
    endtask

    task automatic test_mt_stall();
        int edges;
        bit ok;
        logic [63:0] e;
        logic [31:0] lo_before, hi_before;
        issue(2'd1, 32'd3, 32'd7);
        edges = 1;
        tick(); tick(); edges += 2;
        lo_before = lo_read;
        hi_before = hi_read;
        mtlo   = 1'b1;
        wdata  = 32'h1234;
        rd_req = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mt_stall got=%b exp=1", stall); end
        op = 2'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        tick(); tick(); edges += 2;
        start = 1'b0;
        checks++; if (lo_read !== lo_before) begin errors++; $display("FAIL mt_ignored_busy got=%h exp=%h", lo_read, lo_before); end
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || edges != 34 || {hi_read, lo_read} !== e) begin errors++; $display("FAIL mt_result got=%h_%h edges=%0d exp=%h edges=34", hi_read, lo_read, edges, e); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mt_stall_idle got=%b exp=0", stall); end
        tick();
        checks++; if (lo_read !== 32'h1234 || hi_read !== e[63:32]) begin errors++; $display("FAIL mtlo_write got=%h_%h exp=%h_00001234", hi_read, lo_read, e[63:32]); end
        rd_req = 1'b0;
        mthi   = 1'b1;
        wdata  = 32'hAAAA_5555;
        tick();
        checks++; if (hi_read !== 32'hAAAA_5555 || lo_read !== 32'hAAAA_5555) begin errors++; $display("FAIL mt_both got=%h_%h exp=aaaa5555_aaaa5555", hi_read, lo_read); end
        mthi  = 1'b0;
        wdata = 32'h0000_0BAD;
        issue(2'd1, 32'd2, 32'd2);
        mtlo  = 1'b0;
        checks++; if (lo_read !== 32'hAAAA_5555 || hi_read !== hi_before && hi_read !== 32'hAAAA_5555) begin errors++; $display("FAIL start_beats_mt got=%h exp=aaaa5555", lo_read); end
        edges = 1;
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || {hi_read, lo_read} !== e) begin errors++; $display("FAIL start_beats_mt_result got=%h_%h exp=%h", hi_read, lo_read, e); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0011;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_front());
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (hi_read !== 32'd0 || lo_read !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi_read, lo_read); end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit ok;
        logic [63:0] e;
        issue(2'd3, 32'd100, 32'd7);
        edges = 1;
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || {hi_read, lo_read} !== e) begin errors++; $display("FAIL b2b_first got=%h_%h exp=%h", hi_read, lo_read, e); end
        issue(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        edges = 1;
        wait_done(edges, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || edges != 34 || {hi_read, lo_read} !== e) begin errors++; $display("FAIL b2b_second got=%h_%h edges=%0d exp=%h", hi_read, lo_read, edges, e); end
    endtask

    task automatic test_clk_enable();
        int edges;
        logic [63:0] e;
        op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        exp_q.push_back(model(2'd1, a, b));
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        edges = 1;
        tick(); tick(); edges += 2;
        clk_enable4 = 1'b0;
        rd_req = 1'b1;
        #1;
        checks++; if (stall4 !== 1'b1) begin errors++; $display("FAIL ce_stall got=%b exp=1", stall4); end
        repeat (5) begin tick(); edges++; end
        rd_req = 1'b0;
        checks++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL ce_hold busy=%b done=%b exp=10", busy4, done4); end
        clk_enable4 = 1'b1;
        while (!done4 && edges < 100) begin
            tick();
            edges++;
        end
        e = exp_q.pop_front();
        checks++; if (!done4 || edges != 15) begin errors++; $display("FAIL ce_latency got=%0d exp=15", edges); end
        checks++; if ({hi4, lo4} !== e) begin errors++; $display("FAIL ce_result got=%h_%h exp=%h", hi4, lo4, e); end
        tick();
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL ce_done_width got=%b exp=0", done4); end
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; clk_enable4 = 1'b1;
        start = 1'b0; start4 = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_req = 1'b0;
        test_reset();
        test_multu_max();
        test_signed_and_random();
        test_div_zero();
        test_mt_stall();
        test_reset_mid();
        test_back_to_back();
        test_clk_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair and replaces single-cycle MULT/DIV evaluation in the ALU. It accepts MULT, MULTU, DIV and DIVU commands from the control decode, runs a shift-add or restoring-divide loop over several cycles, then writes HI/LO. It also services MTHI/MTLO writes and asserts a stall so the CPU holds PC while a result is pending.

## Interface
- BITS_PER_CYCLE, 1, quotient/product bits retired per iteration; legal values 1, 2, 4; iteration count N = 32/BITS_PER_CYCLE
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high; clears all state
- clk_enable  input  1  when low, every register (state, counter, HI, LO, done) holds
- start  input  1  command valid (decoded MULT/MULTU/DIV/DIVU)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- operand_a  input  32  rs value (multiplicand / dividend)
- operand_b  input  32  rt value (multiplier / divisor)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  rs value for MTHI/MTLO
- rd_req  input  1  MFHI or MFLO decoded this cycle
- hi_read  output  32  current HI register
- lo_read  output  32  current LO register
- busy  output  1  registered; high whenever state is not IDLE
- done  output  1  registered one-cycle pulse when HI/LO receive a result
- stall  output  1  combinational: busy & (start | mthi | mtlo | rd_req)

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start: latch op, |operand_a|, |operand_b| (absolute value only for signed ops), sign flags; counter = N; go to CALC. Exception: DIV/DIVU with operand_b == 0 goes straight to FIX.
- CALC: one iteration per enabled edge; counter decrements; at counter reaching 0 go to FIX.
  - Multiply: 64-bit accumulator, BITS_PER_CYCLE multiplier bits consumed LSB-first per iteration.
  - Divide: restoring, BITS_PER_CYCLE quotient bits MSB-first per iteration, 33-bit partial remainder.
- FIX: apply sign correction, write HI/LO, go to IDLE, set done.
  - MULT: product negated (64-bit two's complement) if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes dividend's sign.
  - 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0; no trap.
  - Divide by zero (both DIV and DIVU): LO = 0xFFFFFFFF, HI = operand_a as sampled.
- mthi/mtlo in IDLE without start: write HI/LO on the edge; both may fire together. Ignored while busy (stall holds the instruction).
- start with mthi/mtlo in the same IDLE cycle: start wins; MT write dropped.
- start while busy: ignored; stall high so decode re-presents it.
- rd_req: no state effect; only affects stall.

## Timing
- Reset values: state IDLE, HI = 0, LO = 0, busy = 0, done = 0, counter = 0.
- Reset mid-operation: aborts; HI/LO cleared, no done pulse.
- Start-sampling edge = edge 1. busy high after edge 1. HI/LO update and done high after edge N+2; busy low after the same edge. BITS_PER_CYCLE = 1: edge 34.
- Divide by zero: HI/LO and done after edge 2.
- done high for exactly one enabled cycle; a new start can be sampled in that cycle.
- clk_enable low: no state change, no counter change; stall still evaluated combinationally.
- hi_read/lo_read change only on edges that write them.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, BITS_PER_CYCLE = 1 -> after edge 34, HI = 0xFFFFFFFE, LO = 0x00000001, done pulse one cycle.
- MULT -3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0; DIVU 5 / 0 -> after edge 2, LO = 0xFFFFFFFF, HI = 5.
- MTLO 0x1234 during CALC with rd_req high -> stall = 1, LO unchanged until result; after result, MTLO 0x1234 -> LO = 0x1234.
- Reset asserted at edge 10 of a MULTU -> busy = 0, HI = LO = 0, no done.
- clk_enable low for 5 cycles mid-CALC, BITS_PER_CYCLE = 4 -> completion shifts from edge 10 to edge 15; result unchanged.
